// File: rtl/counter_priority_arb_pkg.sv
// counter_priority_arb_pkg: shared FSM encoding and default constants for the counter arbiter
package counter_priority_arb_pkg;
  typedef enum logic {IDLE, SERVE} state_t;
  localparam int NCH_DEF = 16;
  localparam int AW_DEF = 6;
  localparam logic [5:0] BASE_DEF = 6'o42;
endpackage

// File: rtl/counter_priority_arb_prio_pick.sv
// prio_pick: first set request at or after a rotating start index
module prio_pick #(
  parameter int NCH = 16,
  localparam int IW = $clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [IW-1:0]  start,
  output logic [IW-1:0]  idx,
  output logic           valid
);
  // scan from the farthest slot back toward start so the nearest request wins
  always_comb begin
    idx = '0;
    for (int k = NCH - 1; k >= 0; k--)
      if (req[(int'(start) + k) % NCH]) idx = IW'((int'(start) + k) % NCH);
  end
  assign valid = |req;
endmodule

// File: rtl/counter_priority_arb.sv
// counter_priority_arb: collects plus/minus counter requests and grants one memory cycle at a time
module counter_priority_arb
  import counter_priority_arb_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int AW = AW_DEF,
  parameter logic [AW-1:0] BASE = AW'(BASE_DEF),
  parameter int RR = 0,
  localparam int IW = $clog2(NCH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] REQP,
  input  logic [NCH-1:0] REQM,
  input  logic           CYST,
  input  logic           INHIB,
  input  logic           ACK,
  output logic [AW-1:0]  CAD,
  output logic           GNTV,
  output logic           INCP,
  output logic           INCM,
  output logic [NCH-1:0] PENDP,
  output logic [NCH-1:0] PENDM,
  output logic [NCH-1:0] LOST
);
  state_t state, state_n;
  logic [NCH-1:0] reqp_q, reqm_q, pendp, pendm, lost, pendp_n, pendm_n, lost_n;
  logic [NCH-1:0] ep, em, gsel, gp, gm;
  logic [IW-1:0] win, ptr, pick;
  logic armed, dir_p, pick_v, serve, grant;
  assign serve = state == SERVE;
  assign ep = armed ? REQP & ~reqp_q : '0;
  assign em = armed ? REQM & ~reqm_q : '0;
  assign gsel = serve ? NCH'(1) << win : '0;
  assign gp = dir_p ? gsel : '0;
  assign gm = dir_p ? '0 : gsel;
  prio_pick #(.NCH(NCH)) u_pick (
    .req(pendp | pendm),
    .start((RR != 0) ? ptr : IW'(0)),
    .idx(pick),
    .valid(pick_v)
  );
  assign grant = !serve && CYST && !INHIB && pick_v;
  // next state: ACK ends service, an uninhibited cycle start with work pending begins it
  always_comb begin
    state_n = serve ? (ACK ? IDLE : SERVE) : (grant ? SERVE : IDLE);
  end
  // pending bookkeeping: retire the granted flag on ACK, then fold in new edges against that value
  always_comb begin
    pendp_n = pendp;
    pendm_n = pendm;
    lost_n = lost;
    for (int i = 0; i < NCH; i++) begin
      if (ACK && gp[i]) pendp_n[i] = 1'b0;
      if (ACK && gm[i]) pendm_n[i] = 1'b0;
      if (ep[i] && !em[i]) begin
        if (pendm[i] && !gm[i]) pendm_n[i] = 1'b0;
        else if (pendp_n[i]) lost_n[i] = 1'b1;
        else pendp_n[i] = 1'b1;
      end
      if (em[i] && !ep[i]) begin
        if (pendp[i] && !gp[i]) pendp_n[i] = 1'b0;
        else if (pendm_n[i]) lost_n[i] = 1'b1;
        else pendm_n[i] = 1'b1;
      end
    end
  end
  // state, flags and latched grant; inputs high at reset release are absorbed without counting
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      reqp_q <= '0;
      reqm_q <= '0;
      armed <= 1'b0;
      pendp <= '0;
      pendm <= '0;
      lost <= '0;
      win <= '0;
      dir_p <= 1'b0;
      ptr <= '0;
    end else begin
      state <= state_n;
      reqp_q <= REQP;
      reqm_q <= REQM;
      armed <= 1'b1;
      pendp <= pendp_n;
      pendm <= pendm_n;
      lost <= lost_n;
      if (grant) begin
        win <= pick;
        dir_p <= pendp[pick];
        ptr <= (pick == IW'(NCH - 1)) ? '0 : pick + 1'b1;
      end
    end
  end
  assign GNTV = serve;
  assign INCP = serve && dir_p;
  assign INCM = serve && !dir_p;
  assign CAD = serve ? BASE + AW'(win) : '0;
  assign PENDP = pendp;
  assign PENDM = pendm;
  assign LOST = lost;
endmodule

// File: tb/tb_counter_priority_arb.sv
// tb_counter_priority_arb: fixed and round-robin arbiters against a behavioural model
module tb_counter_priority_arb;
  logic clk = 1'b0, rst = 1'b0, CYST, INHIB, ACK;
  logic [15:0] REQP, REQM;
  logic [5:0] cad_f, cad_r;
  logic gntv_f, gntv_r, incp_f, incp_r, incm_f, incm_r;
  logic [15:0] pendp_f, pendp_r, pendm_f, pendm_r, lost_f, lost_r;
  int checks = 0, errors = 0;
  bit [15:0] mp[2], mm[2], ml[2], lastp, lastm;
  bit busy[2], dirp[2], armed;
  int win[2], nxt[2];
  int exp_r[4] = '{0, 1, 2, 0};

  always #5 clk = ~clk;

  counter_priority_arb #(.RR(0)) dut_f (
    .clk(clk), .rst(rst), .REQP(REQP), .REQM(REQM), .CYST(CYST), .INHIB(INHIB), .ACK(ACK),
    .CAD(cad_f), .GNTV(gntv_f), .INCP(incp_f), .INCM(incm_f), .PENDP(pendp_f), .PENDM(pendm_f), .LOST(lost_f));
  counter_priority_arb #(.RR(1)) dut_r (
    .clk(clk), .rst(rst), .REQP(REQP), .REQM(REQM), .CYST(CYST), .INHIB(INHIB), .ACK(ACK),
    .CAD(cad_r), .GNTV(gntv_r), .INCP(incp_r), .INCM(incm_r), .PENDP(pendp_r), .PENDM(pendm_r), .LOST(lost_r));

  task automatic chk(input string nm, input int m, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d got %0h want %0h at %0t", nm, m, act, exp, $time);
    end
  endtask

  task automatic model_step(input int m);
    int w;
    bit [15:0] pe, me, np, nm, nl;
    bit held_p, held_m;
    w = -1;
    if (!busy[m] && CYST && !INHIB)
      for (int k = 0; k < 16; k++) begin
        int j;
        j = ((m == 1 ? nxt[m] : 0) + k) % 16;
        if (w < 0 && (mp[m][j] || mm[m][j])) w = j;
      end
    pe = armed ? REQP & ~lastp : 16'h0;
    me = armed ? REQM & ~lastm : 16'h0;
    np = mp[m];
    nm = mm[m];
    nl = ml[m];
    if (busy[m] && ACK) begin
      if (dirp[m]) np[win[m]] = 1'b0;
      else nm[win[m]] = 1'b0;
    end
    for (int i = 0; i < 16; i++) begin
      held_p = mp[m][i] && !(busy[m] && win[m] == i && dirp[m]);
      held_m = mm[m][i] && !(busy[m] && win[m] == i && !dirp[m]);
      if (pe[i] && !me[i]) begin
        if (held_m) nm[i] = 1'b0;
        else if (np[i]) nl[i] = 1'b1;
        else np[i] = 1'b1;
      end
      if (me[i] && !pe[i]) begin
        if (held_p) np[i] = 1'b0;
        else if (nm[i]) nl[i] = 1'b1;
        else nm[i] = 1'b1;
      end
    end
    if (busy[m] && ACK) busy[m] = 1'b0;
    else if (w >= 0) begin
      busy[m] = 1'b1;
      win[m] = w;
      dirp[m] = mp[m][w];
      nxt[m] = (w + 1) % 16;
    end
    mp[m] = np;
    mm[m] = nm;
    ml[m] = nl;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int m = 0; m < 2; m++) begin
        mp[m] = '0; mm[m] = '0; ml[m] = '0; busy[m] = 1'b0; dirp[m] = 1'b0; win[m] = 0; nxt[m] = 0;
      end
      lastp = '0; lastm = '0; armed = 1'b0;
    end else begin
      model_step(0);
      model_step(1);
      lastp = REQP; lastm = REQM; armed = 1'b1;
    end
  end

  task automatic cmp(input int m, input logic g, input logic [5:0] c, input logic ip, input logic im,
                     input logic [15:0] pp, input logic [15:0] pm, input logic [15:0] lo);
    chk("GNTV", m, 32'(g), 32'(busy[m]));
    chk("CAD", m, 32'(c), busy[m] ? (34 + win[m]) % 64 : 0);
    chk("INCP", m, 32'(ip), 32'(busy[m] && dirp[m]));
    chk("INCM", m, 32'(im), 32'(busy[m] && !dirp[m]));
    chk("PENDP", m, 32'(pp), 32'(mp[m]));
    chk("PENDM", m, 32'(pm), 32'(mm[m]));
    chk("LOST", m, 32'(lo), 32'(ml[m]));
  endtask

  always @(negedge clk) begin
    cmp(0, gntv_f, cad_f, incp_f, incm_f, pendp_f, pendm_f, lost_f);
    cmp(1, gntv_r, cad_r, incp_r, incm_r, pendp_r, pendm_r, lost_r);
  end

  task automatic nx(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic pulse(input bit c, input bit a);
    CYST = c;
    ACK = a;
    nx();
    CYST = 1'b0;
    ACK = 1'b0;
  endtask

  initial begin
    REQP = 16'h0011; REQM = 16'h0100; CYST = 0; INHIB = 0; ACK = 0;
    nx(3);
    chk("rst_gntv", 0, 32'(gntv_f), 0);
    chk("rst_cad", 0, 32'(cad_f), 0);
    rst = 1'b1;
    nx(3);
    chk("rel_pendp", 0, 32'(pendp_f), 0);
    chk("rel_pendm", 0, 32'(pendm_f), 0);
    REQP = 0; REQM = 0;
    nx(2);
    REQP[3] = 1; REQM[7] = 1;
    nx();
    chk("p3_pend", 0, 32'(pendp_f[3]), 1);
    pulse(1, 0);
    chk("g1_cad", 0, 32'(cad_f), 32'(6'o45));
    chk("g1_incp", 0, 32'(incp_f), 1);
    pulse(0, 1);
    chk("a1_pendp3", 0, 32'(pendp_f[3]), 0);
    pulse(1, 0);
    chk("g2_cad", 0, 32'(cad_f), 32'(6'o51));
    chk("g2_incm", 0, 32'(incm_f), 1);
    pulse(0, 1);
    REQP = 0; REQM = 0;
    nx();
    REQP[2] = 1; REQM[2] = 1;
    nx();
    chk("cx_pendp2", 0, 32'(pendp_f[2]), 0);
    chk("cx_pendm2", 0, 32'(pendm_f[2]), 0);
    pulse(1, 0);
    chk("cx_gntv", 0, 32'(gntv_f), 0);
    REQP = 0; REQM = 0;
    nx();
    REQP[5] = 1; nx(); REQP[5] = 0; nx(); REQP[5] = 1; nx();
    chk("lost5", 0, 32'(lost_f[5]), 1);
    pulse(1, 0);
    chk("l5_cad", 0, 32'(cad_f), 32'(6'o47));
    pulse(0, 1);
    chk("l5_pendp", 0, 32'(pendp_f[5]), 0);
    pulse(1, 0);
    chk("l5_once", 0, 32'(gntv_f), 0);
    REQP = 0;
    nx();
    for (int t = 0; t < 4; t++) begin
      REQP[2:0] = 3'b000; nx();
      REQP[2:0] = 3'b111; nx();
      pulse(1, 0);
      chk("rr_cad", 1, 32'(cad_r), 34 + exp_r[t]);
      chk("fix_cad", 0, 32'(cad_f), 34);
      pulse(0, 1);
    end
    REQP = 0;
    repeat (4) begin
      pulse(1, 0);
      pulse(0, 1);
    end
    chk("drain_f", 0, 32'(pendp_f), 0);
    chk("drain_r", 1, 32'(pendp_r), 0);
    REQP[9] = 1; nx();
    INHIB = 1;
    pulse(1, 0);
    chk("inh_gntv", 0, 32'(gntv_f), 0);
    INHIB = 0;
    pulse(1, 0);
    chk("uninh_cad", 0, 32'(cad_f), 32'(6'o53));
    pulse(0, 1);
    REQP = 0;
    nx();
    REQP[4] = 1; REQM[6] = 1; nx();
    pulse(1, 0);
    chk("s6_cad", 0, 32'(cad_f), 32'(6'o46));
    #2 rst = 1'b0;
    #1;
    chk("arst_gntv", 0, 32'(gntv_f), 0);
    chk("arst_cad", 0, 32'(cad_f), 0);
    chk("arst_pendp", 0, 32'(pendp_f), 0);
    chk("arst_pendm", 0, 32'(pendm_f), 0);
    nx(2);
    rst = 1'b1;
    nx(3);
    chk("rel2_pendp", 0, 32'(pendp_f), 0);
    chk("rel2_pendm", 0, 32'(pendm_f), 0);
    REQP = 0; REQM = 0;
    nx(2);
    repeat (3000) begin
      for (int i = 0; i < 16; i++) begin
        if ($urandom_range(15) == 0) REQP[i] = ~REQP[i];
        if ($urandom_range(15) == 0) REQM[i] = ~REQM[i];
      end
      CYST = ($urandom_range(2) == 0);
      ACK = ($urandom_range(2) == 0);
      INHIB = ($urandom_range(7) == 0);
      nx();
    end
    CYST = 0; ACK = 0; INHIB = 0;
    nx(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/counter_priority_arb.md
COUNTER_PRIORITY_ARB -- requirements
Module: counter_priority_arb

Interface
REQ-001 Parameter NCH, default 16, number of counter channels (2..32).
REQ-002 Parameter AW, default 6, counter address width.
REQ-003 Parameter BASE, default 6'o42, address of channel 0; addr = BASE + index, truncated to AW bits.
REQ-004 Parameter RR, default 0; 0 = fixed priority (index 0 highest), 1 = round-robin.
REQ-005 clk  in  1  single system clock; all state changes on the rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 REQP  in  NCH  plus-increment request per channel, level; rising edge counts as one request.
REQ-008 REQM  in  NCH  minus-increment request per channel, level; rising edge counts as one request.
REQ-009 CYST  in  1  one-clk pulse marking a memory-cycle boundary (grant opportunity).
REQ-010 INHIB  in  1  inhibits new grants while high; an outstanding grant is unaffected.
REQ-011 ACK  in  1  one-clk pulse: granted counter cycle completed.
REQ-012 CAD  out  AW  address of granted counter; 0 when no grant.
REQ-013 GNTV  out  1  grant valid.
REQ-014 INCP  out  1  granted operation is plus.
REQ-015 INCM  out  1  granted operation is minus.
REQ-016 PENDP  out  NCH  pending plus flags.
REQ-017 PENDM  out  NCH  pending minus flags.
REQ-018 LOST  out  NCH  sticky flag: a request arrived while the same direction was already pending.

Function
REQ-019 Request edges shall be detected with one registered copy of REQP/REQM; a pending flag shall set on the clk following the input edge.
REQ-020 Simultaneous P and M edges on one channel shall cancel; neither flag sets.
REQ-021 An edge opposite to an already-pending direction shall clear that pending flag (net zero) instead of setting the new one.
REQ-022 A same-direction edge while that flag is pending shall set LOST[i]; the pending flag stays set.
REQ-023 FSM states: IDLE and SERVE only.
REQ-024 IDLE -> SERVE on a clk with CYST=1, INHIB=0 and any pending flag; the winner shall be latched on that edge.
REQ-025 Fixed mode: the winner is the lowest index with PENDP or PENDM set.
REQ-026 RR mode: search begins at (last granted index + 1) mod NCH; the pointer resets to 0.
REQ-027 In SERVE: GNTV=1, CAD = BASE + winner, INCP/INCM show the latched direction; exactly one of INCP/INCM is high.
REQ-028 SERVE -> IDLE on ACK; the winner's pending flag for the granted direction shall clear on the same edge.
REQ-029 An opposite-direction edge on the winner during SERVE shall leave PENDP/PENDM for that channel at the post-ACK net value (granted flag cleared, new flag set); the grant itself is never altered.
REQ-030 A same-direction edge on the winner coinciding with ACK shall leave the flag set for a later grant, without setting LOST.
REQ-031 ACK in IDLE and CYST in SERVE shall be ignored.
REQ-032 Minimum grant latency: request edge at clk n, pending at n+1, GNTV at the edge after the first CYST at or after n+1.
REQ-033 LOST bits clear only at reset.

Reset
REQ-034 On rst low: all pending flags, LOST, edge registers and RR pointer = 0; FSM = IDLE; GNTV, INCP, INCM = 0; CAD = 0.
REQ-035 Reset asserted mid-SERVE shall abandon the grant; no flag survives.
REQ-036 REQ inputs already high at reset release shall not count as edges.

Structure
REQ-037 The FSM state encoding and default BASE/NCH constants shall reside in the shared AGC package.
REQ-038 A single sub-module, prio_pick, shall implement the masked (rotating-start) first-one search, parameterised by NCH.

Verification
REQ-039 Fixed mode, REQP[3] and REQM[7] edges, CYST -> CAD=6'o45, INCP=1; after ACK and next CYST -> CAD=6'o51, INCM=1.
REQ-040 REQP[2] and REQM[2] edge together -> PENDP[2]=PENDM[2]=0, no grant on CYST.
REQ-041 Two REQP[5] edges before service -> LOST[5]=1, one grant only, PENDP[5]=0 after ACK.
REQ-042 RR=1, channels 0,1,2 continuously re-requested -> grant order 0,1,2,0.
REQ-043 INHIB=1 with pending flags during CYST -> GNTV stays 0; clearing INHIB, next CYST grants.
REQ-044 rst low during SERVE -> GNTV=0, CAD=0, all PEND=0 immediately, asynchronously.
